// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int INSTR_W = 32;

    // PC loaded by reset unless a block overrides it
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    // addi x0, x0, 0 -- presented on out_instr whenever nothing is valid
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// 2-entry synchronous FIFO holding fetched {pc, instruction} pairs.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: full/count outputs; pushes into a full FIFO without a pop are dropped.
module fetch_fifo #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic [1:0]   count,
    output logic         empty,
    output logic         full
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         push_ok;
    logic         pop_ok;

    assign empty    = (count_q == 2'd0);
    assign full     = (count_q == 2'd2);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    // A pop frees the slot in the same edge, so a push into a full FIFO is fine then
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Storage, pointers and occupancy; flush wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues reads to a 1-cycle imem, buffers results in a 2-entry FIFO.
// Latency: request in cycle N -> out_valid in N+2; 1 instr/cycle sustained.
// Backpressure: out_ready low stalls issue once FIFO plus in-flight request reach 2 entries.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0]
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               halt,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    localparam int FW = ADDR_W + INSTR_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              inflight_q, inflight_d;
    logic              squash_q, squash_d;

    logic              issue;
    logic              push;
    logic              flush;
    logic              pop;
    logic              fifo_push;
    logic [2:0]        occupancy;
    logic [ADDR_W-1:0] br_aligned;
    logic [FW-1:0]     head_dat;
    logic [1:0]        fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    assign pop        = out_valid & out_ready;
    assign br_aligned = {br_target[ADDR_W-1:2], 2'b00};

    // Slots committed after this edge: buffered + returning - leaving
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

    // Next-state for FSM, PC and in-flight tracking; redirect beats issue, push and pop
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = 1'b0;
        squash_d   = 1'b0;
        issue      = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = RUN;
                if (br_taken) begin
                    pc_d = br_aligned;
                end
            end
            RUN: begin
                issue = ~halt & ~br_taken & (occupancy < 3'd2);
                push  = inflight_q & ~squash_q & ~br_taken;
                if (br_taken) begin
                    pc_d     = br_aligned;
                    flush    = 1'b1;
                    squash_d = 1'b1;
                end else if (issue) begin
                    pc_d       = pc_q + {{(ADDR_W-3){1'b0}}, 3'd4};
                    inflight_d = 1'b1;
                    tag_d      = pc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, PC and in-flight request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            squash_q   <= squash_d;
        end
    end

    // Occupancy accounting keeps the FIFO from overflowing; the full gate is a backstop
    assign fifo_push = push & (~fifo_full | pop);

    fetch_fifo #(
        .W (FW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (fifo_push),
        .push_dat ({tag_q, imem_rdata}),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign out_valid = ~fifo_empty;
    assign out_pc    = fifo_empty ? '0  : head_dat[FW-1 -: ADDR_W];
    assign out_instr = fifo_empty ? NOP : head_dat[INSTR_W-1:0];

endmodule
